// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control slice: opcodes, mux selects,
// FSM states, instruction classes and the per-state control-word decode.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'd1112;
  localparam logic [10:0] OP_SUB  = 11'd1624;
  localparam logic [10:0] OP_AND  = 11'd1104;
  localparam logic [10:0] OP_ORR  = 11'd1360;
  localparam logic [10:0] OP_LDUR = 11'd1986;
  localparam logic [10:0] OP_STUR = 11'd1984;
  localparam logic [9:0]  OP_ADDI = 10'd580;
  localparam logic [9:0]  OP_SUBI = 10'd836;
  localparam logic [7:0]  OP_CBZ  = 8'd180;
  localparam logic [7:0]  OP_CBNZ = 8'd181;
  localparam logic [5:0]  OP_B    = 6'd5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_BR     = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_R, CLS_I, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_CBNZ, CLS_B
  } instr_class_t;

  typedef struct packed {
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg2loc;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_nz;
    logic [1:0] pc_src;
    logic       mem2reg;
    logic       reg_write;
  } ctrl_t;

  // State-only part of the control word; FETCH pc_write and DECODE reg2loc are added in the top.
  function automatic ctrl_t ctrl_for(state_t s, logic nz);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      S_DECODE: c.alu_src_b = SRCB_BR;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: c.reg_write = 1'b1;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write = 1'b1;
        c.mem2reg   = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        c.reg2loc   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_PASSB;
        c.reg2loc       = 1'b1;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PCSRC_ALUOUT;
        c.branch_nz     = nz;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_BR;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/legv8_multicycle_control_if.sv
// Control-unit bundle: IR/memory handshake inputs and datapath control outputs.
interface legv8_multicycle_control_if #(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned ALU_OP_W = 2
);
  logic                run;
  logic [INSTR_W-1:0]  instruction;
  logic                mem_ready;
  logic                alu_zero;
  logic                ir_write;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                reg2loc;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                pc_write;
  logic                pc_write_cond;
  logic                branch_nz;
  logic [1:0]          pc_src;
  logic                mem2reg;
  logic                reg_write;
  logic                illegal;
  logic                fault;
  logic [3:0]          state_o;

  modport master (
    input  run, instruction, mem_ready, alu_zero,
    output ir_write, i_or_d, mem_read, mem_write, reg2loc, alu_src_a, alu_src_b,
           alu_op, pc_write, pc_write_cond, branch_nz, pc_src, mem2reg, reg_write,
           illegal, fault, state_o
  );

  modport slave (
    output run, instruction, mem_ready, alu_zero,
    input  ir_write, i_or_d, mem_read, mem_write, reg2loc, alu_src_a, alu_src_b,
           alu_op, pc_write, pc_write_cond, branch_nz, pc_src, mem2reg, reg_write,
           illegal, fault, state_o
  );
endinterface

// File: rtl/legv8_opcode_decoder.sv
// Combinational opcode classifier: top 11 instruction bits -> instruction class.
module legv8_opcode_decoder
  import legv8_pkg::*;
#(
  parameter bit IMM_EN = 1'b1
) (
  input  logic [10:0]  opcode,
  output instr_class_t cls,
  output logic         illegal,
  output logic         uses_rt
);

  logic [9:0] op10;
  logic [7:0] op8;
  logic [5:0] op6;

  assign op10 = opcode[10:1];
  assign op8  = opcode[10:3];
  assign op6  = opcode[10:5];

  // Shorter opcode fields are checked first so branches win over any 11-bit alias.
  always_comb begin
    cls = CLS_ILLEGAL;
    if (op8 == OP_CBZ)                                      cls = CLS_CBZ;
    else if (op8 == OP_CBNZ)                                cls = CLS_CBNZ;
    else if (op6 == OP_B)                                   cls = CLS_B;
    else if (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) cls = CLS_R;
    else if (opcode == OP_LDUR)                             cls = CLS_LDUR;
    else if (opcode == OP_STUR)                             cls = CLS_STUR;
    else if (IMM_EN && (op10 == OP_ADDI || op10 == OP_SUBI)) cls = CLS_I;
  end

  assign illegal = (cls == CLS_ILLEGAL);
  assign uses_rt = (cls inside {CLS_STUR, CLS_CBZ, CLS_CBNZ});

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control FSM with memory-wait timeout; outputs registered from next state.
module legv8_multicycle_control
  import legv8_pkg::*;
#(
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned ALU_OP_W    = 2,
  parameter bit          IMM_EN      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                      clk,
  input logic                      rst_n,
  legv8_multicycle_control_if.master bus
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t          state, nxt;
  instr_class_t    dec_cls, cls_q;
  logic            dec_illegal, dec_uses_rt;
  logic [CNT_W-1:0] cnt;
  logic            illegal_q, fault_q;
  ctrl_t           ctrl_q;
  logic            waiting, timed_out;
  logic            unused_bits;

  legv8_opcode_decoder #(.IMM_EN(IMM_EN)) u_dec (
    .opcode  (bus.instruction[INSTR_W-1 -: 11]),
    .cls     (dec_cls),
    .illegal (dec_illegal),
    .uses_rt (dec_uses_rt)
  );

  // Operand fields and alu_zero belong to the datapath; the control unit only sees opcodes.
  assign unused_bits = ^{bus.instruction[INSTR_W-12:0], bus.alu_zero};

  assign waiting   = (state inside {S_FETCH, S_MEM_RD, S_MEM_WR});
  assign timed_out = (MEM_TIMEOUT != 0) && (32'(cnt) + 32'd1 == MEM_TIMEOUT);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (bus.run) nxt = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  nxt = S_DECODE;
        else if (timed_out) nxt = S_FAULT;
      end
      S_DECODE: begin
        case (dec_cls)
          CLS_CBZ, CLS_CBNZ:  nxt = S_BRANCH;
          CLS_B:              nxt = S_JUMP;
          CLS_R:              nxt = S_EXEC_R;
          CLS_LDUR, CLS_STUR: nxt = S_MEM_ADDR;
          CLS_I:              nxt = S_EXEC_I;
          default:            nxt = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I:                   nxt = S_WB_R;
      S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP:   nxt = S_FETCH;
      S_MEM_ADDR: nxt = (cls_q == CLS_STUR) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ready)  nxt = S_WB_MEM;
        else if (timed_out) nxt = S_FAULT;
      end
      S_MEM_WR: begin
        if (bus.mem_ready)  nxt = S_FETCH;
        else if (timed_out) nxt = S_FAULT;
      end
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cls_q     <= CLS_ILLEGAL;
      cnt       <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_for(nxt, dec_cls == CLS_CBNZ);
      if (state == S_DECODE) begin
        cls_q <= dec_cls;
        if (dec_illegal) illegal_q <= 1'b1;
      end
      if (nxt == S_FAULT) fault_q <= 1'b1;
      if ((nxt != state) && (nxt inside {S_FETCH, S_MEM_RD, S_MEM_WR}))
        cnt <= '0;
      else if (waiting && !bus.mem_ready && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

  // IR is loaded on the FETCH->DECODE edge, so DECODE reg2loc must come straight from the opcode.
  assign bus.ir_write      = ctrl_q.ir_write;
  assign bus.i_or_d        = ctrl_q.i_or_d;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.reg2loc       = ctrl_q.reg2loc | ((state == S_DECODE) && dec_uses_rt);
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ALU_OP_W'(ctrl_q.alu_op);
  assign bus.pc_write      = ctrl_q.pc_write | ((state == S_FETCH) && bus.mem_ready);
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.branch_nz     = ctrl_q.branch_nz;
  assign bus.pc_src        = ctrl_q.pc_src;
  assign bus.mem2reg       = ctrl_q.mem2reg;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.illegal       = illegal_q;
  assign bus.fault         = fault_q;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed bench: per-cycle vector table plus sequences for memory waits, resets and timeouts.
module tb_legv8_multicycle_control;
  import legv8_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h8B020020;
  localparam logic [31:0] I_STUR = 32'hF8000020;
  localparam logic [31:0] I_LDUR = 32'hF8400020;
  localparam logic [31:0] I_CBNZ = 32'hB5000040;
  localparam logic [31:0] I_CBZ  = 32'hB4000040;
  localparam logic [31:0] I_B    = 32'h14000010;
  localparam logic [31:0] I_ADDI = 32'h91000421;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  // {ir,iod,mr,mw,r2l,asa}_{asb}_{aop}_{pw,pwc,bnz}_{pcs}_{m2r,rw}
  localparam logic [16:0] C_ZERO    = 17'b000000_00_00_000_00_00;
  localparam logic [16:0] C_FETCH   = 17'b101000_01_00_000_00_00;
  localparam logic [16:0] C_FETCH_R = 17'b101000_01_00_100_00_00;
  localparam logic [16:0] C_DEC     = 17'b000000_11_00_000_00_00;
  localparam logic [16:0] C_DEC_RT  = 17'b000010_11_00_000_00_00;
  localparam logic [16:0] C_EXR     = 17'b000001_00_10_000_00_00;
  localparam logic [16:0] C_EXI     = 17'b000001_10_10_000_00_00;
  localparam logic [16:0] C_WBR     = 17'b000000_00_00_000_00_01;
  localparam logic [16:0] C_MADDR   = 17'b000001_10_00_000_00_00;
  localparam logic [16:0] C_MRD     = 17'b011000_00_00_000_00_00;
  localparam logic [16:0] C_WBM     = 17'b000000_00_00_000_00_11;
  localparam logic [16:0] C_MWR     = 17'b010110_00_00_000_00_00;
  localparam logic [16:0] C_BR_NZ   = 17'b000011_00_01_011_01_00;
  localparam logic [16:0] C_BR_Z    = 17'b000011_00_01_010_01_00;
  localparam logic [16:0] C_JMP     = 17'b000000_00_00_100_10_00;

  typedef struct {
    logic        run;
    logic [31:0] instr;
    logic        rdy;
    logic        zero;
    state_t      st;
    logic [16:0] ctrl;
    logic        ill;
  } vec_t;

  localparam int NV = 28;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t vec [NV];

  always #5 clk = ~clk;

  legv8_multicycle_control_if #(.INSTR_W(32), .ALU_OP_W(2)) b0 ();
  legv8_multicycle_control_if #(.INSTR_W(32), .ALU_OP_W(2)) b1 ();

  assign b1.run         = b0.run;
  assign b1.instruction = b0.instruction;
  assign b1.mem_ready   = b0.mem_ready;
  assign b1.alu_zero    = b0.alu_zero;

  legv8_multicycle_control #(.INSTR_W(32), .ALU_OP_W(2), .IMM_EN(1'b1), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  legv8_multicycle_control #(.INSTR_W(32), .ALU_OP_W(2), .IMM_EN(1'b0), .MEM_TIMEOUT(15)) dut_noimm (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  logic [16:0] ctrl0;
  assign ctrl0 = {b0.ir_write, b0.i_or_d, b0.mem_read, b0.mem_write, b0.reg2loc, b0.alu_src_a,
                  b0.alu_src_b, b0.alu_op, b0.pc_write, b0.pc_write_cond, b0.branch_nz,
                  b0.pc_src, b0.mem2reg, b0.reg_write};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [31:0] ins, input logic rdy, input logic z);
    b0.run = r;
    b0.instruction = ins;
    b0.mem_ready = rdy;
    b0.alu_zero = z;
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{1'b0, 32'h0,  1'b0, 1'b0, S_IDLE,     C_ZERO,    1'b0};
    vec[1]  = '{1'b1, 32'h0,  1'b0, 1'b0, S_IDLE,     C_ZERO,    1'b0};
    vec[2]  = '{1'b0, I_ADD,  1'b1, 1'b0, S_FETCH,    C_FETCH_R, 1'b0};
    vec[3]  = '{1'b0, I_ADD,  1'b1, 1'b0, S_DECODE,   C_DEC,     1'b0};
    vec[4]  = '{1'b0, I_ADD,  1'b1, 1'b0, S_EXEC_R,   C_EXR,     1'b0};
    vec[5]  = '{1'b0, I_ADD,  1'b1, 1'b0, S_WB_R,     C_WBR,     1'b0};
    vec[6]  = '{1'b0, I_STUR, 1'b1, 1'b0, S_FETCH,    C_FETCH_R, 1'b0};
    vec[7]  = '{1'b0, I_STUR, 1'b1, 1'b0, S_DECODE,   C_DEC_RT,  1'b0};
    vec[8]  = '{1'b0, I_STUR, 1'b1, 1'b0, S_MEM_ADDR, C_MADDR,   1'b0};
    vec[9]  = '{1'b0, I_STUR, 1'b0, 1'b0, S_MEM_WR,   C_MWR,     1'b0};
    vec[10] = '{1'b0, I_STUR, 1'b1, 1'b0, S_MEM_WR,   C_MWR,     1'b0};
    vec[11] = '{1'b0, I_CBNZ, 1'b1, 1'b0, S_FETCH,    C_FETCH_R, 1'b0};
    vec[12] = '{1'b0, I_CBNZ, 1'b1, 1'b0, S_DECODE,   C_DEC_RT,  1'b0};
    vec[13] = '{1'b0, I_CBNZ, 1'b1, 1'b0, S_BRANCH,   C_BR_NZ,   1'b0};
    vec[14] = '{1'b0, I_CBZ,  1'b1, 1'b1, S_FETCH,    C_FETCH_R, 1'b0};
    vec[15] = '{1'b0, I_CBZ,  1'b1, 1'b1, S_DECODE,   C_DEC_RT,  1'b0};
    vec[16] = '{1'b0, I_CBZ,  1'b1, 1'b1, S_BRANCH,   C_BR_Z,    1'b0};
    vec[17] = '{1'b0, I_B,    1'b1, 1'b0, S_FETCH,    C_FETCH_R, 1'b0};
    vec[18] = '{1'b0, I_B,    1'b1, 1'b0, S_DECODE,   C_DEC,     1'b0};
    vec[19] = '{1'b0, I_B,    1'b1, 1'b0, S_JUMP,     C_JMP,     1'b0};
    vec[20] = '{1'b0, I_ADDI, 1'b1, 1'b0, S_FETCH,    C_FETCH_R, 1'b0};
    vec[21] = '{1'b0, I_ADDI, 1'b1, 1'b0, S_DECODE,   C_DEC,     1'b0};
    vec[22] = '{1'b0, I_ADDI, 1'b1, 1'b0, S_EXEC_I,   C_EXI,     1'b0};
    vec[23] = '{1'b0, I_ADDI, 1'b1, 1'b0, S_WB_R,     C_WBR,     1'b0};
    vec[24] = '{1'b0, I_BAD,  1'b1, 1'b0, S_FETCH,    C_FETCH_R, 1'b0};
    vec[25] = '{1'b0, I_BAD,  1'b1, 1'b0, S_DECODE,   C_DEC,     1'b0};
    vec[26] = '{1'b0, I_BAD,  1'b0, 1'b0, S_FETCH,    C_FETCH,   1'b1};
    vec[27] = '{1'b1, I_BAD,  1'b0, 1'b0, S_FETCH,    C_FETCH,   1'b1};

    rst_n = 1'b0;
    b0.run = 1'b0;
    b0.instruction = '0;
    b0.mem_ready = 1'b0;
    b0.alu_zero = 1'b0;
    @(negedge clk);
    #1;
    check("reset state", 32'(b0.state_o), 32'(S_IDLE));
    check("reset ctrl", 32'(ctrl0), 32'(C_ZERO));
    check("reset flags", {30'b0, b0.illegal, b0.fault}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vec[i].run, vec[i].instr, vec[i].rdy, vec[i].zero);
      check($sformatf("vec%0d state", i), 32'(b0.state_o), 32'(vec[i].st));
      check($sformatf("vec%0d ctrl", i), 32'(ctrl0), 32'(vec[i].ctrl));
      check($sformatf("vec%0d illegal", i), 32'(b0.illegal), 32'(vec[i].ill));
      check($sformatf("vec%0d fault", i), 32'(b0.fault), 32'h0);
      cyc();
    end

    // LDUR with mem_ready withheld for three MEM_RD cycles
    apply(1'b0, I_LDUR, 1'b1, 1'b0);
    check("ldur fetch", 32'(b0.state_o), 32'(S_FETCH));
    cyc();
    apply(1'b0, I_LDUR, 1'b1, 1'b0);
    check("ldur decode ctrl", 32'(ctrl0), 32'(C_DEC));
    cyc();
    apply(1'b0, I_LDUR, 1'b0, 1'b0);
    check("ldur addr ctrl", 32'(ctrl0), 32'(C_MADDR));
    cyc();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, I_LDUR, (k == 3), 1'b0);
      check($sformatf("ldur memrd%0d state", k), 32'(b0.state_o), 32'(S_MEM_RD));
      check($sformatf("ldur memrd%0d ctrl", k), 32'(ctrl0), 32'(C_MRD));
      cyc();
    end
    apply(1'b0, I_LDUR, 1'b0, 1'b0);
    check("ldur wbmem state", 32'(b0.state_o), 32'(S_WB_MEM));
    check("ldur wbmem ctrl", 32'(ctrl0), 32'(C_WBM));
    cyc();

    // Second LDUR, reset asserted while in MEM_RD
    apply(1'b0, I_LDUR, 1'b1, 1'b0);
    cyc();
    apply(1'b0, I_LDUR, 1'b1, 1'b0);
    cyc();
    apply(1'b0, I_LDUR, 1'b0, 1'b0);
    cyc();
    apply(1'b0, I_LDUR, 1'b0, 1'b0);
    check("pre-reset memrd", 32'(b0.state_o), 32'(S_MEM_RD));
    rst_n = 1'b0;
    #1;
    check("midrd reset state", 32'(b0.state_o), 32'(S_IDLE));
    check("midrd reset ctrl", 32'(ctrl0), 32'(C_ZERO));
    check("midrd reset mem_read", 32'(b0.mem_read), 32'h0);
    check("midrd reset illegal", 32'(b0.illegal), 32'h0);
    cyc();
    rst_n = 1'b1;
    apply(1'b0, I_LDUR, 1'b1, 1'b0);
    check("after reset idle", 32'(b0.state_o), 32'(S_IDLE));
    cyc();

    // ADDI: legal with IMM_EN=1, illegal with IMM_EN=0
    apply(1'b1, I_ADDI, 1'b1, 1'b0);
    cyc();
    apply(1'b0, I_ADDI, 1'b1, 1'b0);
    check("noimm fetch", 32'(b1.state_o), 32'(S_FETCH));
    cyc();
    apply(1'b0, I_ADDI, 1'b1, 1'b0);
    check("noimm decode", 32'(b1.state_o), 32'(S_DECODE));
    check("noimm illegal pre", 32'(b1.illegal), 32'h0);
    cyc();
    apply(1'b0, I_ADDI, 1'b0, 1'b0);
    check("noimm back to fetch", 32'(b1.state_o), 32'(S_FETCH));
    check("noimm illegal set", 32'(b1.illegal), 32'h1);
    check("noimm no reg_write", 32'(b1.reg_write), 32'h0);
    check("imm exec_i state", 32'(b0.state_o), 32'(S_EXEC_I));
    check("imm exec_i srcb", 32'(b0.alu_src_b), 32'h2);
    check("imm illegal clear", 32'(b0.illegal), 32'h0);
    cyc();
    apply(1'b0, I_ADDI, 1'b0, 1'b0);
    check("imm wb reg_write", 32'(b0.reg_write), 32'h1);
    check("noimm still no reg_write", 32'(b1.reg_write), 32'h0);
    cyc();

    // Memory timeout in FETCH
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    apply(1'b1, I_ADD, 1'b0, 1'b0);
    cyc();
    for (int k = 1; k <= 15; k++) begin
      apply(1'b0, I_ADD, 1'b0, 1'b0);
      check($sformatf("wait%0d state", k), 32'(b0.state_o), 32'(S_FETCH));
      cyc();
    end
    apply(1'b0, I_ADD, 1'b1, 1'b0);
    check("timeout state", 32'(b0.state_o), 32'(S_FAULT));
    check("timeout fault", 32'(b0.fault), 32'h1);
    check("timeout ctrl", 32'(ctrl0), 32'(C_ZERO));
    for (int k = 0; k < 3; k++) begin
      cyc();
      apply(1'b1, I_ADD, 1'b1, 1'b0);
      check($sformatf("fault hold%0d", k), 32'(b0.state_o), 32'(S_FAULT));
    end
    rst_n = 1'b0;
    #1;
    check("fault cleared", 32'(b0.fault), 32'h0);
    check("fault reset idle", 32'(b0.state_o), 32'(S_IDLE));
    cyc();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
